serial_adder: RTL

Bit-serial N-bit adder with carry-in. It processes operands LSB-first, one bit per clock, through a single full-adder bit cell and a carry flip-flop. It is the sequential stage that consumes the sum/carry of a 1-bit adder cell and turns it into a multi-bit add, trading latency for area. Operands are loaded in parallel and the result is presented in parallel with a one-cycle done pulse.

---
 rtl/serial_adder_pkg.sv | 16 +
 rtl/serial_adder_if.sv | 26 ++
 rtl/serial_adder_full_adder_bit.sv | 29 ++
 rtl/serial_adder.sv | 101 ++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and width helpers for the bit-serial adder.
package serial_adder_pkg;

  // Sequencer states: waiting for a start, or shifting bits through the cell.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Bit counter width. The extra bit keeps WIDTH-1 representable with
  // headroom at WIDTH=64.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Operand/result bundle between a requester (master) and the serial adder (slave).
// Handshake: the master raises start with a/b/cin stable. The adder accepts it
// on any rising edge where busy=0. done is a one-cycle pulse marking sum/cout
// as freshly updated. start seen while busy=1 is dropped, not queued.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_adder_full_adder_bit.sv
// One-bit full adder built from two half-adder cells and an OR for carry-out.

module half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

module full_adder_bit (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  logic s0;
  logic c0;
  logic c1;

  half_adder u_ha0 (.x(x),  .y(y),  .s(s0), .c(c0));
  half_adder u_ha1 (.x(s0), .y(ci), .s(s),  .c(c1));

  // The two half-adder carries can never both be 1, so OR gives the majority.
  assign co = c0 | c1;
endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: parallel load, LSB-first through a single
// full-adder cell, parallel result with a one-cycle done pulse.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  serial_adder_if.slave bus,
  output state_t        state_o
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state_q;
  logic [WIDTH-1:0] a_sr_q;
  logic [WIDTH-1:0] b_sr_q;
  logic [WIDTH-1:0] sum_sr_q;
  logic [WIDTH-1:0] sum_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic             cout_q;
  logic             busy_q;
  logic             done_q;

  logic             s_bit;
  logic             c_bit;
  logic [WIDTH-1:0] sum_sr_d;

  full_adder_bit u_fa (
    .x  (a_sr_q[0]),
    .y  (b_sr_q[0]),
    .ci (carry_q),
    .s  (s_bit),
    .co (c_bit)
  );

  // Next partial-sum value: shift right, new bit enters at the MSB.
  // Written as shift-then-overwrite so WIDTH=1 needs no special case.
  always_comb begin
    sum_sr_d            = sum_sr_q >> 1;
    sum_sr_d[WIDTH-1]   = s_bit;
  end

  // Sequencer, datapath shift registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      sum_sr_q <= '0;
      sum_q    <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_sr_q   <= bus.a;
            b_sr_q   <= bus.b;
            carry_q  <= bus.cin;
            cnt_q    <= '0;
            sum_sr_q <= '0;
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end
        end
        RUN: begin
          a_sr_q   <= a_sr_q >> 1;
          b_sr_q   <= b_sr_q >> 1;
          sum_sr_q <= sum_sr_d;
          carry_q  <= c_bit;
          cnt_q    <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            // Last bit: publish result; the counter is parked at 0 so it
            // never reaches WIDTH.
            sum_q   <= sum_sr_d;
            cout_q  <= c_bit;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign state_o  = state_q;

endmodule
